// File: rtl/and_mux_unit.sv
// and_mux_unit: registered two-way AND-select datapath.
// Each valid cycle it picks (a & b) when sel=0 or (c & d) when sel=1.
// The result lands on e one cycle later, flagged by out_valid.
// Optional feature macro: AND_MUX_ONES_CNT_EN adds a saturating counter of
// all-ones results on ones_cnt. Without it, ones_cnt is tied to zero.
//
// Handshake: valid-only, with no ready. A cycle with in_valid=1 is always
// accepted, and it produces exactly one out_valid=1 cycle one clock later.
// A cycle with in_valid=0 leaves e unchanged and drops out_valid.
module and_mux_unit #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] e,
    output logic             out_valid,
    output logic [CNT_W-1:0] ones_cnt
);

    logic [WIDTH-1:0] r;

    // Next result: gated operand pair chosen by sel.
    always_comb begin
        r = sel ? (c & d) : (a & b);
    end

    // Result register: e only loads on valid cycles, while out_valid follows in_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e         <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                e <= r;
            end
        end
    end

`ifdef AND_MUX_ONES_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    // Ones counter: counts valid all-ones results and sticks at its maximum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (in_valid && (&r) && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign ones_cnt = cnt_q;
`else
    assign ones_cnt = '0;
`endif

endmodule

// File: tb/tb_and_mux_unit.sv
// tb_and_mux_unit: directed, table-driven bench for and_mux_unit.
// Instance u1 uses WIDTH=1 with the default counter width.
// Instance u8 uses WIDTH=8 with CNT_W=2, so that its counter saturates early.
// Counter expectations follow AND_MUX_ONES_CNT_EN: they stay zero when the macro is undefined.
module tb_and_mux_unit;

`ifdef AND_MUX_ONES_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    typedef struct {
        logic       v;
        logic       s;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] c;
        logic [7:0] d;
        logic [7:0] exp_e;
        logic       exp_ov;
    } vec_t;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // u1 signals
    logic        v1, s1;
    logic [0:0]  a1, b1, c1, d1, e1;
    logic        ov1;
    logic [15:0] cnt1;

    // u8 signals
    logic        v8, s8;
    logic [7:0]  a8, b8, c8, d8, e8;
    logic        ov8;
    logic [1:0]  cnt8;

    and_mux_unit #(.WIDTH(1), .CNT_W(16)) u1 (
        .clk(clk), .rst(rst), .in_valid(v1), .sel(s1),
        .a(a1), .b(b1), .c(c1), .d(d1),
        .e(e1), .out_valid(ov1), .ones_cnt(cnt1)
    );

    and_mux_unit #(.WIDTH(8), .CNT_W(2)) u8 (
        .clk(clk), .rst(rst), .in_valid(v8), .sel(s8),
        .a(a8), .b(b8), .c(c8), .d(d8),
        .e(e8), .out_valid(ov8), .ones_cnt(cnt8)
    );

    // sel must be known on every valid cycle
    always @(posedge clk) begin
        if (!rst && v1) assert (!$isunknown(s1)) else $error("sel unknown on u1");
        if (!rst && v8) assert (!$isunknown(s8)) else $error("sel unknown on u8");
    end

    // scoreboard counters and counter models
    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] exp_cnt1 = '0;
    logic [1:0]  exp_cnt8 = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_cnt1 = '0;
        exp_cnt8 = '0;
    endtask

    task automatic apply1(input vec_t t, input int idx);
        v1 = t.v; s1 = t.s;
        a1 = t.a[0:0]; b1 = t.b[0:0]; c1 = t.c[0:0]; d1 = t.d[0:0];
        tick();
        if (CNT_ON && t.v && t.exp_e[0] && exp_cnt1 != 16'hFFFF) exp_cnt1++;
        check($sformatf("u1[%0d].e", idx), 64'(e1), 64'(t.exp_e[0]));
        check($sformatf("u1[%0d].out_valid", idx), 64'(ov1), 64'(t.exp_ov));
        check($sformatf("u1[%0d].ones_cnt", idx), 64'(cnt1), 64'(exp_cnt1));
    endtask

    task automatic apply8(input vec_t t, input int idx);
        v8 = t.v; s8 = t.s; a8 = t.a; b8 = t.b; c8 = t.c; d8 = t.d;
        tick();
        if (CNT_ON && t.v && t.exp_e == 8'hFF && exp_cnt8 != 2'd3) exp_cnt8++;
        check($sformatf("u8[%0d].e", idx), 64'(e8), 64'(t.exp_e));
        check($sformatf("u8[%0d].out_valid", idx), 64'(ov8), 64'(t.exp_ov));
        check($sformatf("u8[%0d].ones_cnt", idx), 64'(cnt8), 64'(exp_cnt8));
    endtask

    // watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
        $fatal(1, "watchdog expired");
    end

    vec_t t1[7];
    vec_t t8[7];

    initial begin
        // WIDTH=1 vectors: {v, sel, a, b, c, d, exp_e, exp_ov}
        t1[0] = '{1'b1, 1'b0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 1'b1};
        t1[1] = '{1'b1, 1'b0, 8'h1, 8'h1, 8'h0, 8'h1, 8'h1, 1'b1};
        t1[2] = '{1'b1, 1'b1, 8'h1, 8'h1, 8'h0, 8'h1, 8'h0, 1'b1};
        t1[3] = '{1'b1, 1'b0, 8'h0, 8'h1, 8'h1, 8'h1, 8'h0, 1'b1};
        t1[4] = '{1'b1, 1'b1, 8'h0, 8'h1, 8'h1, 8'h1, 8'h1, 1'b1};
        t1[5] = '{1'b0, 1'b0, 8'h1, 8'h1, 8'h0, 8'h0, 8'h1, 1'b0};
        t1[6] = '{1'b1, 1'b1, 8'h1, 8'h1, 8'h1, 8'h0, 8'h0, 1'b1};
        // WIDTH=8 vectors, including hold and back-to-back alternating sel
        t8[0] = '{1'b1, 1'b1, 8'h00, 8'h00, 8'hF0, 8'h3C, 8'h30, 1'b1};
        t8[1] = '{1'b0, 1'b0, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h30, 1'b0};
        t8[2] = '{1'b1, 1'b0, 8'hAA, 8'h0F, 8'hFF, 8'hFF, 8'h0A, 1'b1};
        t8[3] = '{1'b1, 1'b1, 8'hAA, 8'h0F, 8'hFF, 8'hFF, 8'hFF, 1'b1};
        t8[4] = '{1'b1, 1'b0, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFF, 1'b1};
        t8[5] = '{1'b1, 1'b1, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 1'b1};
        t8[6] = '{1'b0, 1'b1, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 1'b0};

        // reset held with toggling inputs, checked before any clock edge
        v1 = 1'b1; s1 = 1'b0; a1 = 1'b1; b1 = 1'b1; c1 = 1'b1; d1 = 1'b1;
        v8 = 1'b1; s8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; c8 = 8'hFF; d8 = 8'hFF;
        #1;
        s1 = 1'b1; s8 = 1'b0; a8 = 8'h5A;
        #1;
        check("rst.e1", 64'(e1), 64'd0);
        check("rst.ov1", 64'(ov1), 64'd0);
        check("rst.cnt1", 64'(cnt1), 64'd0);
        check("rst.e8", 64'(e8), 64'd0);
        check("rst.ov8", 64'(ov8), 64'd0);
        check("rst.cnt8", 64'(cnt8), 64'd0);
        v1 = 1'b0; v8 = 1'b0;
        do_reset();

        // first valid after release gives out_valid one cycle later
        check("post_rst.ov1_idle", 64'(ov1), 64'd0);
        for (int i = 0; i < 7; i++) apply1(t1[i], i);
        for (int i = 0; i < 7; i++) apply8(t8[i], i);

        // ones counter: five all-ones results on u1
        v1 = 1'b0; v8 = 1'b0;
        do_reset();
        for (int i = 0; i < 5; i++) apply1('{1'b1, 1'b0, 8'h1, 8'h1, 8'h0, 8'h0, 8'h1, 1'b1}, 10 + i);
        check("cnt1.five", 64'(cnt1), CNT_ON ? 64'd5 : 64'd0);

        // saturation: six all-ones results on u8 with CNT_W=2
        v1 = 1'b0;
        do_reset();
        for (int i = 0; i < 6; i++) apply8('{1'b1, 1'b1, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 1'b1}, 20 + i);
        check("cnt8.sat", 64'(cnt8), CNT_ON ? 64'd3 : 64'd0);

        // reset asserted between edges while out_valid=1
        v8 = 1'b1; s8 = 1'b1; c8 = 8'hF0; d8 = 8'h3C;
        tick();
        check("mid.ov8_before", 64'(ov8), 64'd1);
        check("mid.e8_before", 64'(e8), 64'h30);
        #2;
        rst = 1'b1;
        #1;
        check("mid.e8_cleared", 64'(e8), 64'd0);
        check("mid.ov8_cleared", 64'(ov8), 64'd0);
        check("mid.cnt8_cleared", 64'(cnt8), 64'd0);
        c8 = 8'hFF; d8 = 8'hFF;
        tick();
        check("mid.ov8_no_pulse", 64'(ov8), 64'd0);
        check("mid.e8_held_zero", 64'(e8), 64'd0);
        rst = 1'b0;
        exp_cnt8 = '0;
        c8 = 8'h0F; d8 = 8'h3C;
        tick();
        check("mid.ov8_first_after", 64'(ov8), 64'd1);
        check("mid.e8_first_after", 64'(e8), 64'h0C);
        v8 = 1'b0;
        tick();
        check("mid.ov8_drop", 64'(ov8), 64'd0);
        check("mid.e8_hold", 64'(e8), 64'h0C);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
